// File: rtl/draw_pixel_writer.sv
// Pixel write-back: clips rasterizer pixels and maps survivors to VRAM word/nibble writes queued for the arbiter.
// Latency: a pixel handshaken in cycle N is in S1 at N+1, S2 at N+2 and heads the FIFO (vram_wr_o) at N+3.
// Backpressure: credit based; pix_ready_o drops while DEPTH pixels are in flight, so S1/S2 never stall.
module draw_pixel_writer #(
  parameter int CORDW = 12,
  parameter int ADDRW = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_ni,
  input  logic [ADDRW-1:0]        cfg_dest_addr_i,
  input  logic [ADDRW-1:0]        cfg_dest_words_i,
  input  logic [1:0]              cfg_bpp_i,
  input  logic signed [CORDW-1:0] cfg_clip_x0_i,
  input  logic signed [CORDW-1:0] cfg_clip_y0_i,
  input  logic signed [CORDW-1:0] cfg_clip_x1_i,
  input  logic signed [CORDW-1:0] cfg_clip_y1_i,
  input  logic                    pix_valid_i,
  output logic                    pix_ready_o,
  input  logic signed [CORDW-1:0] pix_x_i,
  input  logic signed [CORDW-1:0] pix_y_i,
  input  logic [7:0]              pix_color_i,
  output logic                    vram_sel_o,
  output logic                    vram_wr_o,
  output logic [3:0]              vram_mask_o,
  output logic [ADDRW-1:0]        vram_addr_o,
  output logic [15:0]             vram_data_o,
  input  logic                    vram_ack_i,
  output logic                    busy_o
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [3:0]       mask;
    logic [15:0]      data;
  } wr_t;

  // S1: raw accepted pixel
  logic                    r_s1_vld;
  logic signed [CORDW-1:0] r_s1_x;
  logic signed [CORDW-1:0] r_s1_y;
  logic [7:0]              r_s1_color;
  // S2: pixel that survived clipping
  logic                    r_s2_vld;
  logic signed [CORDW-1:0] r_s2_x;
  logic signed [CORDW-1:0] r_s2_y;
  logic [7:0]              r_s2_color;
  // FIFO
  wr_t                     r_mem [DEPTH];
  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic [PW:0]             r_count;

  logic                    w_accept;
  logic                    w_s1_pass;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_is4;
  logic                    w_nonempty;
  logic [PW+1:0]           w_inflight;
  logic [ADDRW-1:0]        w_row;
  logic [ADDRW-1:0]        w_xoff;
  wr_t                     w_s2_wr;
  wr_t                     w_head;

  // Every pixel past the handshake owns a FIFO slot, so ready only looks at registered occupancy.
  assign w_inflight  = (PW+2)'(r_count) + (PW+2)'(r_s1_vld) + (PW+2)'(r_s2_vld);
  assign pix_ready_o = w_inflight < (PW+2)'(DEPTH);
  assign w_accept    = pix_valid_i & pix_ready_o;

  // Negative coordinates are rejected even if the clip rectangle would admit them.
  assign w_s1_pass = (r_s1_x >= cfg_clip_x0_i) && (r_s1_x <= cfg_clip_x1_i) &&
                     (r_s1_y >= cfg_clip_y0_i) && (r_s1_y <= cfg_clip_y1_i) &&
                     !r_s1_x[CORDW-1] && !r_s1_y[CORDW-1];

  // Row offset wraps modulo 2^ADDRW; clipped y is non-negative so a zero-extend is exact.
  assign w_is4  = (cfg_bpp_i == 2'd0);
  assign w_row  = ADDRW'($unsigned(r_s2_y)) * cfg_dest_words_i;
  assign w_xoff = w_is4 ? ADDRW'($unsigned(r_s2_x) >> 2) : ADDRW'($unsigned(r_s2_x) >> 1);

  // Build the VRAM word write for the S2 pixel (4 bpp packs four pixels per word, MSB nibble first).
  always_comb begin
    w_s2_wr      = '0;
    w_s2_wr.addr = cfg_dest_addr_i + w_row + w_xoff;
    if (w_is4) begin
      w_s2_wr.mask = 4'b1000 >> r_s2_x[1:0];
      w_s2_wr.data = {4{r_s2_color[3:0]}};
    end else begin
      w_s2_wr.mask = r_s2_x[0] ? 4'b0011 : 4'b1100;
      w_s2_wr.data = {2{r_s2_color}};
    end
  end

  assign w_push     = r_s2_vld;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = vram_ack_i & w_nonempty;
  assign w_head     = r_mem[r_rptr];

  // Head is gated so the bus reads zero whenever nothing is requested.
  assign vram_wr_o   = w_nonempty;
  assign vram_sel_o  = w_nonempty;
  assign vram_addr_o = w_nonempty ? w_head.addr : '0;
  assign vram_mask_o = w_nonempty ? w_head.mask : '0;
  assign vram_data_o = w_nonempty ? w_head.data : '0;
  assign busy_o      = r_s1_vld | r_s2_vld | w_nonempty;

  // Advance the two-stage pipe; a clip failure simply drops the valid, releasing its credit.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_s1_vld   <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_color <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_x     <= '0;
      r_s2_y     <= '0;
      r_s2_color <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_x     <= pix_x_i;
        r_s1_y     <= pix_y_i;
        r_s1_color <= pix_color_i;
      end
      r_s2_vld <= r_s1_vld & w_s1_pass;
      if (r_s1_vld) begin
        r_s2_x     <= r_s1_x;
        r_s2_y     <= r_s1_y;
        r_s2_color <= r_s1_color;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_s2_wr;
  end

endmodule

// File: tb/tb_draw_pixel_writer.sv
module tb_draw_pixel_writer;
  localparam int CORDW = 12;
  localparam int ADDRW = 16;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    reset_ni;
  logic [ADDRW-1:0]        cfg_dest_addr_i;
  logic [ADDRW-1:0]        cfg_dest_words_i;
  logic [1:0]              cfg_bpp_i;
  logic signed [CORDW-1:0] cfg_clip_x0_i, cfg_clip_y0_i, cfg_clip_x1_i, cfg_clip_y1_i;
  logic                    pix_valid_i;
  logic                    pix_ready_o;
  logic signed [CORDW-1:0] pix_x_i, pix_y_i;
  logic [7:0]              pix_color_i;
  logic                    vram_sel_o, vram_wr_o;
  logic [3:0]              vram_mask_o;
  logic [ADDRW-1:0]        vram_addr_o;
  logic [15:0]             vram_data_o;
  logic                    vram_ack_i;
  logic                    busy_o;

  draw_pixel_writer #(.CORDW(CORDW), .ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_ni(reset_ni),
    .cfg_dest_addr_i(cfg_dest_addr_i), .cfg_dest_words_i(cfg_dest_words_i), .cfg_bpp_i(cfg_bpp_i),
    .cfg_clip_x0_i(cfg_clip_x0_i), .cfg_clip_y0_i(cfg_clip_y0_i),
    .cfg_clip_x1_i(cfg_clip_x1_i), .cfg_clip_y1_i(cfg_clip_y1_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .pix_x_i(pix_x_i), .pix_y_i(pix_y_i), .pix_color_i(pix_color_i),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
    .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o),
    .vram_ack_i(vram_ack_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        pass;
    int unsigned addr;
    int unsigned mask;
    int unsigned data;
    int          a;
  } exp_t;

  function automatic exp_t model(input int x, input int y, input int col);
    exp_t e;
    int unsigned base;
    e.pass = (x >= int'(cfg_clip_x0_i)) && (x <= int'(cfg_clip_x1_i)) &&
             (y >= int'(cfg_clip_y0_i)) && (y <= int'(cfg_clip_y1_i)) && (x >= 0) && (y >= 0);
    e.addr = 0; e.mask = 0; e.data = 0; e.a = 0;
    if (e.pass) begin
      base = int'(cfg_dest_addr_i) + y * int'(cfg_dest_words_i);
      if (cfg_bpp_i == 2'd0) begin
        e.addr = (base + x / 4) % 65536;
        e.mask = 8 >> (x % 4);
        e.data = (col % 16) * 32'h1111;
      end else begin
        e.addr = (base + x / 2) % 65536;
        e.mask = (x % 2 == 1) ? 3 : 12;
        e.data = col * 257;
      end
    end
    return e;
  endfunction

  exp_t        q[$];
  logic        prev_disc = 1'b0;
  int          nwrites = 0;
  int          npass = 0;
  int unsigned last_addr = 0, last_mask = 0, last_data = 0;
  int          last_lat = 0;
  int          infl;
  logic        ewr;
  exp_t        ne;

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset_ni) begin
      chk("rst_wr", vram_wr_o, 0);
      chk("rst_sel", vram_sel_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", pix_ready_o, 1);
      chk("rst_bus", {vram_addr_o, vram_mask_o, 12'h000}, 0);
      chk("rst_data", vram_data_o, 0);
      q.delete();
      prev_disc = 1'b0;
    end else begin
      infl = q.size() + (prev_disc ? 1 : 0);
      ewr  = (q.size() > 0) && (cyc >= q[0].a + 3);
      chk("ready", pix_ready_o, (infl < DEPTH) ? 1 : 0);
      chk("busy", busy_o, (infl > 0) ? 1 : 0);
      chk("wr", vram_wr_o, ewr);
      chk("sel", vram_sel_o, ewr);
      if (ewr) begin
        chk("head_addr", vram_addr_o, q[0].addr);
        chk("head_mask", vram_mask_o, q[0].mask);
        chk("head_data", vram_data_o, q[0].data);
        if (vram_ack_i) begin
          ne = q.pop_front();
          nwrites++;
          last_addr = ne.addr; last_mask = ne.mask; last_data = ne.data;
          last_lat  = cyc - ne.a;
        end
      end
      prev_disc = 1'b0;
      if (pix_valid_i && (infl < DEPTH)) begin
        ne   = model(int'(pix_x_i), int'(pix_y_i), int'(pix_color_i));
        ne.a = cyc;
        if (ne.pass) begin
          q.push_back(ne);
          npass++;
        end else begin
          prev_disc = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input int x, input int y, input int col);
    logic acc;
    acc = 1'b0;
    pix_x_i = CORDW'(x); pix_y_i = CORDW'(y); pix_color_i = 8'(col); pix_valid_i = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = pix_ready_o;
      @(posedge clk); #1;
    end
    pix_valid_i = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 500 && busy_o; k++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", busy_o, 0);
  endtask

  task automatic set_cfg(input int dest, input int words, input int bpp,
                         input int x0, input int y0, input int x1, input int y1);
    cfg_dest_addr_i = ADDRW'(dest); cfg_dest_words_i = ADDRW'(words); cfg_bpp_i = 2'(bpp);
    cfg_clip_x0_i = CORDW'(x0); cfg_clip_y0_i = CORDW'(y0);
    cfg_clip_x1_i = CORDW'(x1); cfg_clip_y1_i = CORDW'(y1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n0, p0, acc_cnt, ack_pct;
  logic pend;

  initial begin
    reset_ni = 1'b0; pix_valid_i = 1'b0; pix_x_i = '0; pix_y_i = '0; pix_color_i = '0;
    vram_ack_i = 1'b0;
    set_cfg(0, 0, 1, 0, 0, 2047, 2047);
    repeat (3) @(posedge clk);
    #1 reset_ni = 1'b1;

    // Single 8 bpp pixel
    vram_ack_i = 1'b1;
    set_cfg('h1000, 80, 1, 0, 0, 2047, 2047);
    n0 = nwrites;
    send(5, 2, 'hA7);
    wait_idle();
    chk("s8_count", nwrites - n0, 1);
    chk("s8_addr", last_addr, 'h10A2);
    chk("s8_mask", last_mask, 'b0011);
    chk("s8_data", last_data, 'hA7A7);
    chk("s8_latency", last_lat, 3);

    // Single 4 bpp pixel
    set_cfg(0, 40, 0, 0, 0, 2047, 2047);
    n0 = nwrites;
    send(6, 1, 'h3C);
    wait_idle();
    chk("s4_count", nwrites - n0, 1);
    chk("s4_addr", last_addr, 'h0029);
    chk("s4_mask", last_mask, 'b0010);
    chk("s4_data", last_data, 'hCCCC);

    // Clipping: only (9,9) survives
    set_cfg(0, 10, 1, 0, 0, 9, 9);
    n0 = nwrites;
    send(-1, 0, 'h11); send(10, 3, 'h22); send(9, 9, 'h55); send(0, 10, 'h33);
    wait_idle();
    chk("clip_count", nwrites - n0, 1);
    chk("clip_addr", last_addr, 'h005E);
    chk("clip_mask", last_mask, 'b0011);
    chk("clip_data", last_data, 'h5555);
    chk("clip_ready", pix_ready_o, 1);

    // Backpressure: 10-pixel stream with the arbiter stalled, then released
    set_cfg('h0200, 64, 1, 0, 0, 2047, 2047);
    n0 = nwrites; vram_ack_i = 1'b0; acc_cnt = 0;
    for (int cy = 0; cy < 300 && acc_cnt < 10; cy++) begin
      pix_x_i = CORDW'(acc_cnt); pix_y_i = CORDW'(1); pix_color_i = 8'(acc_cnt + 1); pix_valid_i = 1'b1;
      if (cy == 8) begin
        chk("bp_accepts", acc_cnt, DEPTH);
        chk("bp_ready_low", pix_ready_o, 0);
        chk("bp_wr_held", vram_wr_o, 1);
        vram_ack_i = 1'b1;
      end
      @(negedge clk); if (pix_ready_o) acc_cnt++;
      @(posedge clk); #1;
    end
    pix_valid_i = 1'b0;
    chk("bp_all_accepted", acc_cnt, 10);
    wait_idle();
    chk("bp_count", nwrites - n0, 10);
    chk("bp_last_data", last_data, 'h0A0A);

    // Randomized traffic, two destination formats (bpp=2 behaves as 8 bpp)
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) set_cfg('hF000, 300, 2, 2, 1, 35, 30);
      else         set_cfg('h0100, 17, 0, 3, 0, 39, 25);
      n0 = nwrites; p0 = npass; acc_cnt = 0; pend = 1'b0; ack_pct = 30;
      for (int cy = 0; cy < 20000 && acc_cnt < 500; cy++) begin
        if (cy % 50 == 0) ack_pct = (ack_pct == 30) ? 90 : 30;
        vram_ack_i = ($urandom_range(0, 99) < ack_pct);
        if (!pend && $urandom_range(0, 4) != 0) begin
          pix_x_i = CORDW'(int'($urandom_range(0, 44)) - 4);
          pix_y_i = CORDW'(int'($urandom_range(0, 36)) - 3);
          pix_color_i = 8'($urandom_range(0, 255));
          pix_valid_i = 1'b1; pend = 1'b1;
        end
        @(negedge clk);
        if (pix_valid_i && pix_ready_o) begin acc_cnt++; pend = 1'b0; end
        @(posedge clk); #1;
        if (!pend) pix_valid_i = 1'b0;
      end
      pix_valid_i = 1'b0; vram_ack_i = 1'b1;
      chk("rand_accepted", acc_cnt, 500);
      wait_idle();
      chk("rand_all_written", nwrites - n0, npass - p0);
    end

    // Reset mid-operation: 2 pixels in FIFO, 2 in S1/S2
    set_cfg(0, 32, 1, 0, 0, 2047, 2047);
    vram_ack_i = 1'b0; acc_cnt = 0;
    for (int cy = 0; cy < 50 && acc_cnt < 4; cy++) begin
      pix_x_i = CORDW'(2 * acc_cnt); pix_y_i = CORDW'(3); pix_color_i = 8'h40 + 8'(acc_cnt); pix_valid_i = 1'b1;
      @(negedge clk); if (pix_ready_o) acc_cnt++;
      @(posedge clk); #1;
    end
    pix_valid_i = 1'b0;
    chk("pre_rst_wr", vram_wr_o, 1);
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_wr", vram_wr_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", pix_ready_o, 1);
    chk("mid_rst_addr", vram_addr_o, 0);
    vram_ack_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_ni = 1'b1;
    n0 = nwrites;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_stale", nwrites - n0, 0);
    send(7, 2, 'h9E);
    wait_idle();
    chk("post_rst_count", nwrites - n0, 1);
    chk("post_rst_addr", last_addr, 'h0043);
    chk("post_rst_data", last_data, 'h9E9E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
